timer_event_service: RTL and testbench

Consumer-side servicer for the 8-bit timer's status flags: overflow, input capture and output compare. It detects raised flags, arbitrates between them, and presents one event at a time (code plus captured value) to a downstream consumer over a valid/ready handshake. It then drives the matching ACK back to the timer until the flag drops. It sits between the timer's flag outputs / ACK inputs and the control logic or CPU.

---
 rtl/timer_event_service_pkg.sv | 32 +++
 rtl/timer_evt_watchdog.sv | 36 +++
 rtl/timer_event_service.sv | 154 +++++++++++++++
 tb/tb_timer_event_service.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_event_service_pkg.sv
// Shared types and helpers for the timer event servicer: FSM states, event codes and the
// fixed-priority flag encoder.
package timer_event_service_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPresent,
        StAck,
        StRelease
    } state_e;

    localparam logic [1:0] EVT_NONE = 2'd0;
    localparam logic [1:0] EVT_OVF  = 2'd1;
    localparam logic [1:0] EVT_CAP  = 2'd2;
    localparam logic [1:0] EVT_CMP  = 2'd3;

    // Capture beats overflow beats compare.
    function automatic logic [1:0] prio_encode(input logic cap, input logic ovf, input logic cmp);
        logic [1:0] code;
        if (cap) begin
            code = EVT_CAP;
        end else if (ovf) begin
            code = EVT_OVF;
        end else if (cmp) begin
            code = EVT_CMP;
        end else begin
            code = EVT_NONE;
        end
        return code;
    endfunction

endpackage

// File: rtl/timer_evt_watchdog.sv
// ACK hold watchdog: counts cycles while start_i is high and pulses expired_o during the
// ACK_TIMEOUT-th cycle so the caller leaves ACK after exactly ACK_TIMEOUT cycles.
module timer_evt_watchdog #(
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam logic [7:0] LastCnt = 8'(ACK_TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    assign expired_o = start_i && (cnt_q == LastCnt);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (start_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_event_service.sv
// Timer flag servicer: arbitrates overflow/capture/compare flags, presents one event over
// valid/ready, then ACKs until the flag drops. Optional counter under TIMER_EVT_STATS_EN.
module timer_event_service
    import timer_event_service_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 15,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iTimerOverflow,
    input  logic              iCapturaFlag,
    input  logic [DATA_W-1:0] ivCaptura,
    input  logic              iComparisonTrueFlag,
    output logic              oTimerOverflowACK,
    output logic              oInputCaptureACK,
    output logic              oOutputCompareACK,
    output logic              oEventValid,
    input  logic              iEventReady,
    output logic [1:0]        ovEventCode,
    output logic [DATA_W-1:0] ovEventData,
    output logic              oTimeoutErr,
    input  logic              iErrClr,
    output logic [7:0]        ovServicedCount
);

    state_e            state_q, state_d;
    logic [1:0]        code_q, code_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              sel_flag;
    logic              expired;
    logic              timeout;
    logic [1:0]        pick;
    logic              in_ack;

    assign in_ack = (state_q == StAck);

    timer_evt_watchdog #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_watchdog (
        .clk_i    (iClk),
        .rst_i    (iReset),
        .start_i  (in_ack),
        .clear_i  (!in_ack),
        .expired_o(expired)
    );

    always_comb begin
        sel_flag = 1'b0;
        unique case (code_q)
            EVT_OVF: sel_flag = iTimerOverflow;
            EVT_CAP: sel_flag = iCapturaFlag;
            EVT_CMP: sel_flag = iComparisonTrueFlag;
            default: sel_flag = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        data_d  = data_q;
        timeout = 1'b0;
        pick    = prio_encode(iCapturaFlag, iTimerOverflow, iComparisonTrueFlag);
        unique case (state_q)
            StIdle: begin
                if (pick != EVT_NONE) begin
                    code_d  = pick;
                    data_d  = (pick == EVT_CAP) ? ivCaptura : '0;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (iEventReady) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                // A falling flag wins over a coincident expiry: the event was serviced.
                if (!sel_flag || expired) begin
                    timeout = sel_flag;
                    code_d  = EVT_NONE;
                    data_d  = '0;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (iErrClr) begin
            err_d = 1'b0;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q <= StIdle;
            code_q  <= EVT_NONE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign oEventValid       = (state_q == StPresent);
    assign ovEventCode       = code_q;
    assign ovEventData       = data_q;
    assign oTimeoutErr       = err_q;
    assign oTimerOverflowACK = in_ack && (code_q == EVT_OVF);
    assign oInputCaptureACK  = in_ack && (code_q == EVT_CAP);
    assign oOutputCompareACK = in_ack && (code_q == EVT_CMP);

`ifdef TIMER_EVT_STATS_EN
    logic [7:0] svc_cnt_q, svc_cnt_d;
    logic       svc_done;

    assign svc_done = in_ack && !sel_flag;

    always_comb begin
        svc_cnt_d = svc_cnt_q;
        if (svc_done && (svc_cnt_q != 8'hFF)) begin
            svc_cnt_d = svc_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            svc_cnt_q <= '0;
        end else begin
            svc_cnt_q <= svc_cnt_d;
        end
    end

    assign ovServicedCount = svc_cnt_q;
`else
    assign ovServicedCount = '0;
`endif

endmodule

// File: tb/tb_timer_event_service.sv
// Directed self-checking bench for timer_event_service (default parameters).
module tb_timer_event_service;

    logic       iClk = 1'b0;
    logic       iReset;
    logic       iTimerOverflow;
    logic       iCapturaFlag;
    logic [7:0] ivCaptura;
    logic       iComparisonTrueFlag;
    logic       oTimerOverflowACK;
    logic       oInputCaptureACK;
    logic       oOutputCompareACK;
    logic       oEventValid;
    logic       iEventReady;
    logic [1:0] ovEventCode;
    logic [7:0] ovEventData;
    logic       oTimeoutErr;
    logic       iErrClr;
    logic [7:0] ovServicedCount;

    int n_cmp = 0;
    int n_err = 0;
    int exp_svc = 0;

    logic [2:0]  ack_vec;
    logic [22:0] all_out;

    assign ack_vec = {oTimerOverflowACK, oInputCaptureACK, oOutputCompareACK};
    assign all_out = {oEventValid, ovEventCode, ovEventData, ack_vec, oTimeoutErr,
                      ovServicedCount};

    always #5 iClk = ~iClk;

    timer_event_service dut (
        .iClk               (iClk),
        .iReset             (iReset),
        .iTimerOverflow     (iTimerOverflow),
        .iCapturaFlag       (iCapturaFlag),
        .ivCaptura          (ivCaptura),
        .iComparisonTrueFlag(iComparisonTrueFlag),
        .oTimerOverflowACK  (oTimerOverflowACK),
        .oInputCaptureACK   (oInputCaptureACK),
        .oOutputCompareACK  (oOutputCompareACK),
        .oEventValid        (oEventValid),
        .iEventReady        (iEventReady),
        .ovEventCode        (ovEventCode),
        .ovEventData        (ovEventData),
        .oTimeoutErr        (oTimeoutErr),
        .iErrClr            (iErrClr),
        .ovServicedCount    (ovServicedCount)
    );

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    function automatic logic [7:0] exp_count();
`ifdef TIMER_EVT_STATS_EN
        return (exp_svc > 255) ? 8'hFF : 8'(exp_svc);
`else
        return 8'h00;
`endif
    endfunction

    task automatic test_reset();
        iReset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (all_out !== 23'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        iReset = 1'b0;
        tick();
        n_cmp++;
        if (oEventValid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_no_flag: valid got %b want 0", oEventValid);
        end
        iComparisonTrueFlag = 1'b1;
        iEventReady = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (ack_vec !== 3'b001) begin
            n_err++;
            $display("FAIL reset_pre_ack: acks got %b want 001", ack_vec);
        end
        iReset = 1'b1;
        #1;
        n_cmp++;
        if (all_out !== 23'h0) begin
            n_err++;
            $display("FAIL reset_mid_ack: got %h want 0", all_out);
        end
        exp_svc = 0;
        tick();
        iReset = 1'b0;
        iComparisonTrueFlag = 1'b0;
        tick();
        n_cmp++;
        if ({oEventValid, ack_vec} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_restart_idle: got %b want 0000", {oEventValid, ack_vec});
        end
        iComparisonTrueFlag = 1'b1;
        tick();
        n_cmp++;
        if ({oEventValid, ovEventCode} !== 3'b1_11) begin
            n_err++;
            $display("FAIL reset_restart_present: got %b want 111", {oEventValid, ovEventCode});
        end
        tick();
        iComparisonTrueFlag = 1'b0;
        tick();
        tick();
        exp_svc++;
        iEventReady = 1'b0;
    endtask

    task automatic test_capture();
        int hi = 0;
        ivCaptura = 8'h2A;
        iCapturaFlag = 1'b1;
        iEventReady = 1'b1;
        tick();
        n_cmp++;
        if ({oEventValid, ovEventCode, ovEventData} !== {1'b1, 2'd2, 8'h2A}) begin
            n_err++;
            $display("FAIL cap_present: got %h want %h", {oEventValid, ovEventCode, ovEventData},
                     {1'b1, 2'd2, 8'h2A});
        end
        ivCaptura = 8'hFF;
        tick();
        n_cmp++;
        if ({oEventValid, ack_vec, ovEventData} !== {4'b0010, 8'h2A}) begin
            n_err++;
            $display("FAIL cap_ack_start: got %h want %h", {oEventValid, ack_vec, ovEventData},
                     {4'b0010, 8'h2A});
        end
        for (int i = 0; i < 3; i++) begin
            if (oInputCaptureACK === 1'b1) hi++;
            if (i == 2) iCapturaFlag = 1'b0;
            tick();
        end
        n_cmp++;
        if (hi !== 3) begin
            n_err++;
            $display("FAIL cap_ack_cycles: got %0d want 3", hi);
        end
        exp_svc++;
        n_cmp++;
        if ({oEventValid, ovEventCode, ovEventData, ack_vec} !== 14'h0) begin
            n_err++;
            $display("FAIL cap_release: got %h want 0",
                     {oEventValid, ovEventCode, ovEventData, ack_vec});
        end
        // Re-raise in RELEASE: IDLE next cycle, PRESENT the one after.
        ivCaptura = 8'h13;
        iCapturaFlag = 1'b1;
        tick();
        n_cmp++;
        if (oEventValid !== 1'b0) begin
            n_err++;
            $display("FAIL cap_release_one_cycle: valid got %b want 0", oEventValid);
        end
        tick();
        n_cmp++;
        if ({oEventValid, ovEventData} !== {1'b1, 8'h13}) begin
            n_err++;
            $display("FAIL cap_second_present: got %h want %h", {oEventValid, ovEventData},
                     {1'b1, 8'h13});
        end
        tick();
        iCapturaFlag = 1'b0;
        tick();
        tick();
        exp_svc++;
        iEventReady = 1'b0;
    endtask

    task automatic test_simultaneous();
        iTimerOverflow = 1'b1;
        iComparisonTrueFlag = 1'b1;
        iEventReady = 1'b1;
        tick();
        n_cmp++;
        if ({oEventValid, ovEventCode, ovEventData} !== {1'b1, 2'd1, 8'h00}) begin
            n_err++;
            $display("FAIL sim_first_ovf: got %h want %h", {oEventValid, ovEventCode, ovEventData},
                     {1'b1, 2'd1, 8'h00});
        end
        tick();
        n_cmp++;
        if (ack_vec !== 3'b100) begin
            n_err++;
            $display("FAIL sim_ovf_ack: got %b want 100", ack_vec);
        end
        iTimerOverflow = 1'b0;
        tick();
        exp_svc++;
        n_cmp++;
        if ({oEventValid, ack_vec} !== 4'b0000) begin
            n_err++;
            $display("FAIL sim_release: got %b want 0000", {oEventValid, ack_vec});
        end
        tick();
        n_cmp++;
        if (oEventValid !== 1'b0) begin
            n_err++;
            $display("FAIL sim_idle_gap: valid got %b want 0", oEventValid);
        end
        tick();
        n_cmp++;
        if ({oEventValid, ovEventCode} !== 3'b1_11) begin
            n_err++;
            $display("FAIL sim_cmp_present: got %b want 111", {oEventValid, ovEventCode});
        end
        tick();
        n_cmp++;
        if (ack_vec !== 3'b001) begin
            n_err++;
            $display("FAIL sim_cmp_ack: got %b want 001", ack_vec);
        end
        iComparisonTrueFlag = 1'b0;
        tick();
        tick();
        exp_svc++;
        iEventReady = 1'b0;
    endtask

    task automatic test_backpressure();
        iEventReady = 1'b0;
        iComparisonTrueFlag = 1'b1;
        tick();
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if ({oEventValid, ovEventCode, ack_vec} !== 6'b1_11_000) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got %b want 111000", i,
                         {oEventValid, ovEventCode, ack_vec});
            end
            tick();
        end
        iEventReady = 1'b1;
        tick();
        n_cmp++;
        if (ack_vec !== 3'b001) begin
            n_err++;
            $display("FAIL bp_ack: got %b want 001", ack_vec);
        end
        iComparisonTrueFlag = 1'b0;
        tick();
        tick();
        exp_svc++;
        iEventReady = 1'b0;
    endtask

    task automatic test_timeout();
        int hi = 0;
        iTimerOverflow = 1'b1;
        iEventReady = 1'b1;
        tick();
        tick();
        while (oTimerOverflowACK === 1'b1 && hi < 40) begin
            hi++;
            // Clear requested in the same cycle the timeout sets: set must win.
            if (hi == 15) iErrClr = 1'b1;
            tick();
        end
        iErrClr = 1'b0;
        n_cmp++;
        if (hi !== 15) begin
            n_err++;
            $display("FAIL to_ack_cycles: got %0d want 15", hi);
        end
        n_cmp++;
        if ({oTimeoutErr, oEventValid, ack_vec, ovEventCode} !== 7'b1_0_000_00) begin
            n_err++;
            $display("FAIL to_err_set: got %b want 1000000",
                     {oTimeoutErr, oEventValid, ack_vec, ovEventCode});
        end
        iEventReady = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({oTimeoutErr, oEventValid, ovEventCode} !== 4'b1_1_01) begin
            n_err++;
            $display("FAIL to_represent: got %b want 1101", {oTimeoutErr, oEventValid, ovEventCode});
        end
        iTimerOverflow = 1'b0;
        iEventReady = 1'b1;
        tick();
        tick();
        exp_svc++;
        tick();
        n_cmp++;
        if (oTimeoutErr !== 1'b1) begin
            n_err++;
            $display("FAIL to_err_sticky: got %b want 1", oTimeoutErr);
        end
        iErrClr = 1'b1;
        tick();
        iErrClr = 1'b0;
        n_cmp++;
        if (oTimeoutErr !== 1'b0) begin
            n_err++;
            $display("FAIL to_err_clear: got %b want 0", oTimeoutErr);
        end
        iEventReady = 1'b0;
    endtask

    task automatic test_stats();
        n_cmp++;
        if (ovServicedCount !== exp_count()) begin
            n_err++;
            $display("FAIL stats_before: got %0d want %0d", ovServicedCount, exp_count());
        end
        iEventReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            iCapturaFlag = 1'b1;
            tick();
            tick();
            iCapturaFlag = 1'b0;
            tick();
            tick();
            exp_svc++;
        end
        n_cmp++;
        if (ovServicedCount !== exp_count()) begin
            n_err++;
            $display("FAIL stats_after: got %0d want %0d", ovServicedCount, exp_count());
        end
        iEventReady = 1'b0;
    endtask

    initial begin
        iReset = 1'b1;
        iTimerOverflow = 1'b0;
        iCapturaFlag = 1'b0;
        ivCaptura = 8'h00;
        iComparisonTrueFlag = 1'b0;
        iEventReady = 1'b0;
        iErrClr = 1'b0;
        test_reset();
        test_capture();
        test_simultaneous();
        test_backpressure();
        test_timeout();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
